// File: rtl/sccb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_pkg
// Shared definitions for the SCCB read initiator: the transaction state
// enumeration, the slot tick geometry and a helper that maps a bus position
// (state + quarter tick) onto the SIOC / SIOD pin levels.
// -----------------------------------------------------------------------------
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START1,
    WR_ID,
    WR_ADDR,
    STOP1,
    GAP,
    START2,
    RD_ID,
    RD_DATA,
    NA,
    STOP2,
    FINISH
  } sccb_state_e;

  localparam int unsigned TICKS_PER_SLOT = 4;
  localparam int unsigned SAMPLE_TICK    = 2;
  localparam int unsigned READ_BIT       = 1;
  localparam int unsigned NUM_SLOTS      = 41;

  localparam logic [1:0] LAST_TICK  = 2'(TICKS_PER_SLOT - 1);
  localparam logic [1:0] SAMPLE_Q   = 2'(SAMPLE_TICK);
  localparam logic [3:0] ACK_BIT    = 4'd8;
  localparam logic [3:0] LAST_DBIT  = 4'd7;

  // Pin levels {sioc, siod_oe} for quarter q of a slot of type st.
  // tx_bit is the data bit for byte slots; 1 releases SIOD.
  function automatic logic [1:0] slot_drive(sccb_state_e st, logic [1:0] q,
                                            logic tx_bit);
    logic [1:0] d;
    d = 2'b10;
    case (st)
      START1, START2: begin
        case (q)
          2'd0:    d = 2'b10;
          2'd3:    d = 2'b01;
          default: d = 2'b11;
        endcase
      end
      WR_ID, WR_ADDR, RD_ID, RD_DATA, NA: d = {q[1], ~tx_bit};
      STOP1, STOP2: begin
        case (q)
          2'd0:    d = 2'b01;
          2'd1:    d = 2'b11;
          default: d = 2'b10;
        endcase
      end
      default: d = 2'b10;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// -----------------------------------------------------------------------------
// sccb_tick_gen
// Divides clk by DIV and emits a one-cycle quarter-tick strobe on the last
// cycle of every DIV-cycle period. The counter is held at zero while en is
// low, so the first quarter after en rises lasts exactly DIV cycles.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   en   : count enable (transaction in progress)
//   tick : quarter-tick strobe
// -----------------------------------------------------------------------------
module sccb_tick_gen #(
  parameter int unsigned DIV = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/sccb_reader.sv
// -----------------------------------------------------------------------------
// sccb_reader
// SCCB read initiator: START, write ID, sub-address, STOP, gap, START,
// read ID, one data byte, NA, STOP. Each bus slot is four quarter ticks.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   start    : request a read (honoured only when idle)
//   reg_addr : sub-address, latched with start
//   sioc     : SCCB clock
//   siod_oe  : 1 pulls SIOD low, 0 releases it
//   siod_in  : SIOD pin level
//   busy     : transaction in progress
//   done     : one-cycle end-of-transaction pulse
//   rdata    : last byte read
//   ack_err  : slave failed to acknowledge (only with ACK checking)
// Build option: define SCCB_READER_ACK_CHECK_EN to sample the three ACK slots
// and abort to the current phase's STOP on a NAK.
// -----------------------------------------------------------------------------
module sccb_reader #(
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter int unsigned SCCB_FREQ = 100000,
  parameter logic [7:0]  DEV_ID    = 8'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] reg_addr,
  output logic       sioc,
  output logic       siod_oe,
  input  logic       siod_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_err
);

  import sccb_pkg::*;

  localparam int unsigned DIV_CALC = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int unsigned DIV      = (DIV_CALC < 2) ? 2 : DIV_CALC;

  sccb_state_e state, nxt_state;
  logic [1:0]  q, nxt_q;
  logic [3:0]  bitn, nxt_bit;
  logic [7:0]  addr;
  logic [7:0]  shift;
  logic        siod_s1, siod_s2;
  logic        ack_flag;
  logic        tick;
  logic        sample;

  sccb_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      siod_s1 <= 1'b1;
      siod_s2 <= 1'b1;
    end else begin
      siod_s1 <= siod_in;
      siod_s2 <= siod_s1;
    end
  end

  assign sample  = tick && (q == SAMPLE_Q);
  assign ack_err = ack_flag;

  // Bit to place on SIOD for a given byte slot; ACK and read slots release.
  function automatic logic tx_bit_of(sccb_state_e st, logic [3:0] b,
                                     logic [7:0] a);
    logic [7:0] byte_v;
    logic       bit_v;
    case (st)
      WR_ID:   byte_v = DEV_ID;
      WR_ADDR: byte_v = a;
      RD_ID:   byte_v = DEV_ID | 8'(READ_BIT);
      default: byte_v = 8'hFF;
    endcase
    bit_v = 1'b1;
    if (b < ACK_BIT) bit_v = byte_v[3'd7 - b[2:0]];
    return bit_v;
  endfunction

  // Bus position after the current clock. ack_flag can only be set when ACK
  // checking is built in, so the abort branches are inert otherwise.
  always_comb begin
    nxt_state = state;
    nxt_q     = q;
    nxt_bit   = bitn;
    if (tick) begin
      nxt_q = q + 2'd1;
      if (q == LAST_TICK) begin
        nxt_bit = '0;
        case (state)
          START1:  nxt_state = WR_ID;
          WR_ID: begin
            if (bitn != ACK_BIT)  nxt_bit   = bitn + 4'd1;
            else if (ack_flag)    nxt_state = STOP1;
            else                  nxt_state = WR_ADDR;
          end
          WR_ADDR: begin
            if (bitn != ACK_BIT)  nxt_bit   = bitn + 4'd1;
            else                  nxt_state = STOP1;
          end
          STOP1:   nxt_state = ack_flag ? FINISH : GAP;
          GAP:     nxt_state = START2;
          START2:  nxt_state = RD_ID;
          RD_ID: begin
            if (bitn != ACK_BIT)  nxt_bit   = bitn + 4'd1;
            else if (ack_flag)    nxt_state = STOP2;
            else                  nxt_state = RD_DATA;
          end
          RD_DATA: begin
            if (bitn != LAST_DBIT) nxt_bit   = bitn + 4'd1;
            else                   nxt_state = NA;
          end
          NA:      nxt_state = STOP2;
          STOP2:   nxt_state = FINISH;
          default: nxt_state = state;
        endcase
      end
    end
  end

  // Pins are registered from the position being entered, so they change on
  // the same edge as the quarter boundary rather than one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      q        <= '0;
      bitn     <= '0;
      addr     <= '0;
      shift    <= '0;
      rdata    <= '0;
      ack_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sioc     <= 1'b1;
      siod_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr     <= reg_addr;
            ack_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= START1;
            q        <= '0;
            bitn     <= '0;
            {sioc, siod_oe} <= slot_drive(START1, 2'd0, 1'b1);
          end
        end
        FINISH: state <= IDLE;
        default: begin
          if (sample && state == RD_DATA) shift <= {shift[6:0], siod_s2};
`ifdef SCCB_READER_ACK_CHECK_EN
          if (sample && bitn == ACK_BIT && siod_s2 &&
              (state == WR_ID || state == WR_ADDR || state == RD_ID))
            ack_flag <= 1'b1;
`else
          ack_flag <= 1'b0;
`endif
          state <= nxt_state;
          q     <= nxt_q;
          bitn  <= nxt_bit;
          {sioc, siod_oe} <= slot_drive(nxt_state, nxt_q,
                                        tx_bit_of(nxt_state, nxt_bit, addr));
          if (nxt_state == FINISH) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (!ack_flag) rdata <= shift;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_reader.sv
// -----------------------------------------------------------------------------
// tb_sccb_reader
// Drives sccb_reader (DIV = 10) against a behavioural SCCB slave that decodes
// START/STOP and bytes off the pins and answers reads from a random register
// file. Expected bus traffic, busy length and read data come from the
// protocol rules, not from the design's internals.
// -----------------------------------------------------------------------------
module tb_sccb_reader;

  localparam int          DIV         = 10;
  localparam int          SLOT        = 4 * DIV;
  localparam int          FULL_SLOTS  = 41;  // 1+9+9+1+1+1+9+8+1+1
  localparam int          ABORT_SLOTS = 20;  // START, ID+ACK, ADDR+ACK, STOP
  localparam int          EV_START    = 256;
  localparam int          EV_STOP     = 257;
  localparam logic [7:0]  ID          = 8'h42;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start;
  logic [7:0] reg_addr;
  logic       sioc, siod_oe, siod_in, busy, done, ack_err;
  logic [7:0] rdata;

  int checks   = 0;
  int failures = 0;

  sccb_reader #(.CLK_FREQ(400), .SCCB_FREQ(10), .DEV_ID(ID)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reg_addr (reg_addr),
    .sioc     (sioc),
    .siod_oe  (siod_oe),
    .siod_in  (siod_in),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .ack_err  (ack_err)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [7:0] mem [256];
  logic       slave_pull = 1'b0;
  logic       nak_addr   = 1'b0;
  logic       s_sioc_q = 1'b1, s_siod_q = 1'b1, s_rd = 1'b0;
  logic [7:0] s_sh = '0, s_addr = '0;
  int         s_bit = 0, s_byte = 0;
  int         ev_q[$];
  int         exp_q[$];

  assign siod_in = ~(siod_oe | slave_pull);

  always @(negedge clk) begin
    if (!rst) begin
      slave_pull = 1'b0;
      s_bit = 0; s_byte = 0; s_rd = 1'b0;
    end else if (s_sioc_q && sioc && s_siod_q && !siod_in) begin
      ev_q.push_back(EV_START);
      s_bit = 0; s_byte = 0; s_rd = 1'b0; slave_pull = 1'b0;
    end else if (s_sioc_q && sioc && !s_siod_q && siod_in) begin
      ev_q.push_back(EV_STOP);
      slave_pull = 1'b0;
    end else if (!s_sioc_q && sioc) begin
      if (s_bit < 8) begin
        s_sh = {s_sh[6:0], siod_in};
        s_bit++;
        if (s_bit == 8) begin
          ev_q.push_back(int'(s_sh));
          if (s_byte == 0) s_rd = s_sh[0];
          else if (s_byte == 1 && !s_rd) s_addr = s_sh;
        end
      end else begin
        s_bit = 0;
        s_byte++;
      end
    end else if (s_sioc_q && !sioc) begin
      slave_pull = 1'b0;
      if (s_bit == 8 && (s_byte == 0 || !s_rd))
        slave_pull = !(nak_addr && s_byte == 1);
      else if (s_rd && s_byte == 1 && s_bit < 8)
        slave_pull = !mem[s_addr][7 - s_bit];
    end
    s_sioc_q = sioc;
    s_siod_q = siod_in;
  end

  // ---------------- monitors ----------------
  int   cyc = 0, busy_cnt = 0, done_cnt = 0, idle_viol = 0, db_viol = 0;
  int   rises[$];
  logic m_sioc_q = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (done && busy) db_viol++;
    if (!busy && (sioc !== 1'b1 || siod_oe !== 1'b0)) idle_viol++;
    if (busy && sioc && !m_sioc_q) rises.push_back(cyc);
    m_sioc_q = sioc;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack_q(input int qv[$]);
    logic [71:0] s;
    s = '0;
    for (int i = 0; i < qv.size() && i < 8; i++) s = {s[62:0], 9'(qv[i])};
    return s;
  endfunction

  task automatic start_txn(input logic [7:0] a);
    @(posedge clk); #1;
    busy_cnt = 0; done_cnt = 0;
    ev_q.delete(); rises.delete();
    start = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    start = 1'b0; reg_addr = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done) begin got = 1'b1; break; end
    end
    chk({tag, ".done_seen"}, 72'(got), 72'd1);
  endtask

  task automatic wait_busy(input string tag, input int n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (busy_cnt >= n) begin got = 1'b1; break; end
    end
    chk({tag, ".busy_reached"}, 72'(got), 72'd1);
  endtask

  logic [7:0] last_rd = 8'h00;

  task automatic check_txn(input string tag, input logic [7:0] a, input bit nak);
    logic [7:0] d;
    bit         abort;
    d     = mem[a];
    abort = 1'b0;
`ifdef SCCB_READER_ACK_CHECK_EN
    abort = nak;
`endif
    exp_q.delete();
    exp_q.push_back(EV_START); exp_q.push_back(int'(ID));
    exp_q.push_back(int'(a));  exp_q.push_back(EV_STOP);
    if (!abort) begin
      exp_q.push_back(EV_START); exp_q.push_back(int'(ID | 8'h01));
      exp_q.push_back(int'(d));  exp_q.push_back(EV_STOP);
    end
    chk({tag, ".busy_cycles"}, 72'(busy_cnt),
        72'((abort ? ABORT_SLOTS : FULL_SLOTS) * SLOT));
    chk({tag, ".done_pulses"}, 72'(done_cnt), 72'd1);
    chk({tag, ".rdata"}, 72'(rdata), 72'(abort ? last_rd : d));
    chk({tag, ".ack_err"}, 72'(ack_err), 72'(abort));
    chk({tag, ".bus_len"}, 72'(ev_q.size()), 72'(exp_q.size()));
    chk({tag, ".bus_seq"}, pack_q(ev_q), pack_q(exp_q));
    if (!abort) last_rd = d;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] a, a2;

  initial begin
    start = 1'b0;
    reg_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h0A] = 8'h76;

    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.sioc",    72'(sioc),    72'd1);
    chk("rst.siod_oe", 72'(siod_oe), 72'd0);
    chk("rst.busy",    72'(busy),    72'd0);
    chk("rst.done",    72'(done),    72'd0);
    chk("rst.rdata",   72'(rdata),   72'h00);
    chk("rst.ack_err", 72'(ack_err), 72'd0);
    @(negedge clk); rst = 1'b1;

    // Fixed read of 0x0A returning 0x76.
    start_txn(8'h0A);
    wait_done("fixed");
    check_txn("fixed", 8'h0A, 1'b0);
    chk("fixed.sioc_rises",  72'(rises.size()), 72'd38);  // 36 bit clocks + 2 STOPs
    chk("fixed.sioc_period", 72'(rises[1] - rises[0]), 72'(SLOT));

    // Random addresses against random register contents.
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom);
      start_txn(a);
      wait_done("rand");
      check_txn("rand", a, 1'b0);
    end

    // start while busy must not disturb the transaction in flight.
    a = 8'h3C;
    start_txn(a);
    wait_busy("ignore", 100);
    start = 1'b1; reg_addr = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore");
    check_txn("ignore", a, 1'b0);

    // Known previous data, then a NAK on the address byte.
    start_txn(8'h0A);
    wait_done("pre_nak");
    check_txn("pre_nak", 8'h0A, 1'b0);
    a = 8'hC3;
    nak_addr = 1'b1;
    start_txn(a);
    wait_done("nak");
    nak_addr = 1'b0;
    check_txn("nak", a, 1'b1);

    // Reset around slot 20: pins idle at once and no done pulse.
    start_txn(8'h21);
    wait_busy("mid_rst", 20 * SLOT);
    rst = 1'b0;
    #1;
    chk("mid_rst.pins", 72'({sioc, siod_oe, busy, done}), 72'(4'b1000));
    repeat (5) @(negedge clk);
    #1;
    chk("mid_rst.no_done", 72'(done_cnt), 72'd0);
    chk("mid_rst.rdata",   72'(rdata),    72'h00);
    last_rd = 8'h00;
    rst = 1'b1;

    a = 8'($urandom);
    start_txn(a);
    wait_done("post_rst");
    check_txn("post_rst", a, 1'b0);

    // Back-to-back: second start in the cycle right after done.
    a  = 8'($urandom);
    a2 = 8'($urandom);
    start_txn(a);
    wait_done("b2b_1");
    check_txn("b2b_1", a, 1'b0);
    start_txn(a2);
    wait_done("b2b_2");
    check_txn("b2b_2", a2, 1'b0);

    chk("bus_idle_when_not_busy", 72'(idle_viol), 72'd0);
    chk("done_with_busy",         72'(db_viol),   72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
